// File: rtl/req_capture8_pkg.sv
// rtl/req_capture8_pkg.sv - shared types and helpers for the req_capture8 request capture stage
//
// Package req_capture_pkg:
//   NUM_LINES / IDX_W : line count and encoded index width
//   req_vec_t         : one bit per request line
//   req_idx_t         : encoded line index
//   idx_onehot()      : index -> one-hot line vector
package req_capture_pkg;

    localparam int NUM_LINES = 8;
    localparam int IDX_W     = 3;

    typedef logic [NUM_LINES-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]     req_idx_t;

    function automatic req_vec_t idx_onehot(input req_idx_t idx);
        idx_onehot = req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/req_capture8_if.sv
// rtl/req_capture8_if.sv - request/acknowledge bundle between line drivers, capture stage and encoder
//
// Signals:
//   req_in   : raw request lines
//   mask     : per-line output enable
//   ack      : consumer served one request this cycle
//   ack_idx  : index of the served line, qualified by ack
//   ovf_clr  : clear all overflow flags
//   pend_out : masked pending vector (encoder request vector)
//   pend_any : OR of pend_out (encoder enable)
//   overflow : sticky per-line lost-event flags
// Modports: slave = capture stage, master = surrounding logic.
interface req_capture8_if;
    import req_capture_pkg::*;

    req_vec_t req_in;
    req_vec_t mask;
    logic     ack;
    req_idx_t ack_idx;
    logic     ovf_clr;
    req_vec_t pend_out;
    logic     pend_any;
    req_vec_t overflow;

    modport slave (
        input  req_in, mask, ack, ack_idx, ovf_clr,
        output pend_out, pend_any, overflow
    );

    modport master (
        output req_in, mask, ack, ack_idx, ovf_clr,
        input  pend_out, pend_any, overflow
    );
endinterface

// File: rtl/req_capture8_sync2.sv
// rtl/req_capture8_sync2.sv - parameterised-width two-flop synchronizer
//
// Ports:
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input vector
//   q   : synchronized output, two clocks behind d
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/req_capture8.sv
// rtl/req_capture8.sv - eight-line request capture stage feeding an 8-to-3 priority encoder
//
// Parameters:
//   EDGE_MODE : per-line mode, 1 = rising-edge capture with ack clear, 0 = level-follow
// Ports:
//   clk : single clock
//   rst : synchronous active-high reset
//   bus : req_capture8_if.slave (requests, mask, ack, overflow clear, encoder outputs)
// Build option:
//   REQ_CAPTURE_SYNC_EN : insert a two-flop synchronizer on req_in (latency 2 -> 4 clocks)
module req_capture8
    import req_capture_pkg::*;
#(
    parameter req_vec_t EDGE_MODE = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    req_capture8_if.slave  bus
);

    req_vec_t req_s;
    req_vec_t req_q;
    req_vec_t req_d;
    req_vec_t pend;
    req_vec_t ovf;

    req_vec_t set_v;
    req_vec_t clr_v;
    req_vec_t pend_nxt;
    req_vec_t ovf_nxt;

`ifdef REQ_CAPTURE_SYNC_EN
    sync2 #(
        .WIDTH (NUM_LINES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req_in),
        .q   (req_s)
    );
`else
    assign req_s = bus.req_in;
`endif

    always_comb begin
        set_v    = req_q & ~req_d;
        clr_v    = bus.ack ? idx_onehot(bus.ack_idx) : '0;
        // Set beats clear on the same bit so a fresh event is never lost.
        pend_nxt = (EDGE_MODE & ((pend & ~clr_v) | set_v)) | (~EDGE_MODE & req_q);
        // A new overflow beats a simultaneous clear.
        ovf_nxt  = (bus.ovf_clr ? '0 : ovf) | (EDGE_MODE & set_v & pend & ~clr_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
            req_d <= '0;
            pend  <= '0;
            ovf   <= '0;
        end else begin
            req_q <= req_s;
            req_d <= req_q;
            pend  <= pend_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Masking is purely on the output; hidden lines keep their state.
    assign bus.pend_out = pend & bus.mask;
    assign bus.pend_any = |bus.pend_out;
    assign bus.overflow = ovf;

endmodule

// File: tb/tb_req_capture8.sv
// tb/tb_req_capture8.sv - directed self-checking bench for req_capture8
module tb_req_capture8;
    import req_capture_pkg::*;

`ifdef REQ_CAPTURE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    req_capture8_if bus_e();
    req_capture8_if bus_l();

    req_capture8 #(.EDGE_MODE(8'hFF)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e)
    );

    req_capture8 #(.EDGE_MODE(8'h7F)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus_e.req_in = '0; bus_e.mask = 8'hFF; bus_e.ack = 0; bus_e.ack_idx = '0; bus_e.ovf_clr = 0;
        bus_l.req_in = '0; bus_l.mask = 8'hFF; bus_l.ack = 0; bus_l.ack_idx = '0; bus_l.ovf_clr = 0;
    endtask

    task automatic ack_e(input req_idx_t idx);
        bus_e.ack = 1; bus_e.ack_idx = idx;
        tick(1);
        bus_e.ack = 0;
    endtask

    task automatic pulse_e(input req_vec_t v);
        bus_e.req_in = v;
        tick(1);
        bus_e.req_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus_e.req_in = 8'h01;
        rst = 1;
        tick(2);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00 || bus_e.pend_any !== 1'b0 || bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state pend_out=%h pend_any=%b overflow=%h want 00/0/00",
                     bus_e.pend_out, bus_e.pend_any, bus_e.overflow);
        end
        rst = 0;
        tick(LAT - 1);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release_early pend_out=%h want 00", bus_e.pend_out);
        end
        tick(1);
        n_cmp++;
        if (bus_e.pend_out !== 8'h01 || bus_e.pend_any !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_edge pend_out=%h pend_any=%b want 01/1", bus_e.pend_out, bus_e.pend_any);
        end
        n_cmp++;
        if (bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release_ovf overflow=%h want 00", bus_e.overflow);
        end
        tick(2);
        ack_e(3'd0);
        bus_e.req_in = '0;
        tick(LAT + 1);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_line_ack pend_out=%h want 00", bus_e.pend_out);
        end
    endtask

    task automatic test_two_lines();
        bus_e.req_in = 8'h80;
        tick(1);
        bus_e.req_in = 8'h08;
        tick(1);
        bus_e.req_in = 8'h00;
        tick(LAT);
        n_cmp++;
        if (bus_e.pend_out !== 8'h88) begin
            n_bad++;
            $display("FAIL two_lines_set pend_out=%h want 88", bus_e.pend_out);
        end
        ack_e(3'd7);
        n_cmp++;
        if (bus_e.pend_out !== 8'h08 || bus_e.pend_any !== 1'b1) begin
            n_bad++;
            $display("FAIL two_lines_ack7 pend_out=%h pend_any=%b want 08/1", bus_e.pend_out, bus_e.pend_any);
        end
        ack_e(3'd3);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00 || bus_e.pend_any !== 1'b0) begin
            n_bad++;
            $display("FAIL two_lines_ack3 pend_out=%h pend_any=%b want 00/0", bus_e.pend_out, bus_e.pend_any);
        end
    endtask

    task automatic test_set_clear_collision();
        pulse_e(8'h20);
        tick(LAT + 1);
        // Second edge: ack lands in the cycle where set_5 is asserted.
        bus_e.req_in = 8'h20;
        tick(LAT - 1);
        bus_e.req_in = 8'h00;
        ack_e(3'd5);
        n_cmp++;
        if (bus_e.pend_out !== 8'h20 || bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL set_beats_clear pend_out=%h overflow=%h want 20/00", bus_e.pend_out, bus_e.overflow);
        end
        tick(LAT);
        ack_e(3'd5);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00) begin
            n_bad++;
            $display("FAIL set_clear_cleanup pend_out=%h want 00", bus_e.pend_out);
        end
    endtask

    task automatic test_overflow();
        pulse_e(8'h04);
        tick(LAT + 1);
        n_cmp++;
        if (bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL ovf_first_event overflow=%h want 00", bus_e.overflow);
        end
        pulse_e(8'h04);
        tick(LAT + 1);
        n_cmp++;
        if (bus_e.overflow !== 8'h04 || bus_e.pend_out !== 8'h04) begin
            n_bad++;
            $display("FAIL ovf_set overflow=%h pend_out=%h want 04/04", bus_e.overflow, bus_e.pend_out);
        end
        tick(5);
        n_cmp++;
        if (bus_e.overflow !== 8'h04) begin
            n_bad++;
            $display("FAIL ovf_sticky overflow=%h want 04", bus_e.overflow);
        end
        bus_e.ovf_clr = 1;
        tick(1);
        bus_e.ovf_clr = 0;
        n_cmp++;
        if (bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL ovf_clear overflow=%h want 00", bus_e.overflow);
        end
        // New overflow lands in the same cycle as ovf_clr.
        bus_e.req_in = 8'h04;
        tick(LAT - 1);
        bus_e.req_in = 8'h00;
        bus_e.ovf_clr = 1;
        tick(1);
        bus_e.ovf_clr = 0;
        n_cmp++;
        if (bus_e.overflow !== 8'h04) begin
            n_bad++;
            $display("FAIL ovf_new_beats_clr overflow=%h want 04", bus_e.overflow);
        end
    endtask

    task automatic test_reset_midway();
        rst = 1;
        tick(1);
        rst = 0;
        n_cmp++;
        if (bus_e.pend_out !== 8'h00 || bus_e.overflow !== 8'h00 || bus_e.pend_any !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midway pend_out=%h overflow=%h pend_any=%b want 00/00/0",
                     bus_e.pend_out, bus_e.overflow, bus_e.pend_any);
        end
        tick(LAT + 1);
    endtask

    task automatic test_mask();
        bus_e.mask = 8'hFE;
        pulse_e(8'h01);
        tick(LAT + 1);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00 || bus_e.pend_any !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_hidden pend_out=%h pend_any=%b want 00/0", bus_e.pend_out, bus_e.pend_any);
        end
        bus_e.mask = 8'hFF;
        #1;
        n_cmp++;
        if (bus_e.pend_out !== 8'h01 || bus_e.pend_any !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_unmask pend_out=%h pend_any=%b want 01/1", bus_e.pend_out, bus_e.pend_any);
        end
        ack_e(3'd4);
        n_cmp++;
        if (bus_e.pend_out !== 8'h01 || bus_e.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL ack_nonpending pend_out=%h overflow=%h want 01/00", bus_e.pend_out, bus_e.overflow);
        end
        ack_e(3'd0);
        n_cmp++;
        if (bus_e.pend_out !== 8'h00) begin
            n_bad++;
            $display("FAIL mask_cleanup pend_out=%h want 00", bus_e.pend_out);
        end
    endtask

    task automatic test_level_mode();
        bus_l.req_in = 8'h80;
        tick(LAT - 1);
        n_cmp++;
        if (bus_l.pend_out !== 8'h00) begin
            n_bad++;
            $display("FAIL level_rise_early pend_out=%h want 00", bus_l.pend_out);
        end
        tick(1);
        n_cmp++;
        if (bus_l.pend_out !== 8'h80 || bus_l.pend_any !== 1'b1) begin
            n_bad++;
            $display("FAIL level_rise pend_out=%h pend_any=%b want 80/1", bus_l.pend_out, bus_l.pend_any);
        end
        bus_l.ack = 1; bus_l.ack_idx = 3'd7;
        tick(1);
        bus_l.ack = 0;
        tick(1);
        n_cmp++;
        if (bus_l.pend_out !== 8'h80 || bus_l.overflow !== 8'h00) begin
            n_bad++;
            $display("FAIL level_ack_ignored pend_out=%h overflow=%h want 80/00", bus_l.pend_out, bus_l.overflow);
        end
        bus_l.req_in = 8'h00;
        tick(LAT - 1);
        n_cmp++;
        if (bus_l.pend_out !== 8'h80) begin
            n_bad++;
            $display("FAIL level_fall_early pend_out=%h want 80", bus_l.pend_out);
        end
        tick(1);
        n_cmp++;
        if (bus_l.pend_out !== 8'h00 || bus_l.pend_any !== 1'b0) begin
            n_bad++;
            $display("FAIL level_fall pend_out=%h pend_any=%b want 00/0", bus_l.pend_out, bus_l.pend_any);
        end
    endtask

    initial begin
        test_reset();
        test_two_lines();
        test_set_clear_collision();
        test_overflow();
        test_reset_midway();
        test_mask();
        test_level_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
